// File: rtl/fifo_burst_reader.sv
// Read-side drain for the dual-clock FIFO.
// Emits length-headed bursts on a valid/ready stream.
module fifo_burst_reader #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH_EXP  = 10,
  parameter int BURST_LEN  = 64,
  parameter int TIMEOUT    = 256
) (
  input  logic                  rd_clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_valid,
  input  logic [DEPTH_EXP-1:0]  fifo_rd_data_count,
  output logic                  fifo_rd_en,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  busy,
  output logic [15:0]           burst_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [DEPTH_EXP-1:0] BLEN = DEPTH_EXP'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, HEADER, STREAM} state_e;

  state_e                state_q;
  logic [TW-1:0]         timer_q;
  logic [DEPTH_EXP-1:0]  len_q;
  logic [DEPTH_EXP-1:0]  popped_q;
  logic [DEPTH_EXP-1:0]  sent_q;
  logic [WORD_WIDTH-1:0] buf0_q;
  logic [WORD_WIDTH-1:0] buf1_q;
  logic [1:0]            cnt_q;
  logic                  inflight_q;
  logic [15:0]           count_q;

  logic       start;
  logic       xfer;
  logic       pay_xfer;
  logic       last_beat;
  logic [2:0] occ;

  assign start = (fifo_rd_data_count >= BLEN) ||
                 ((fifo_rd_data_count != '0) && (timer_q == TMAX));

  assign m_first   = (state_q == HEADER);
  assign m_valid   = m_first || ((state_q == STREAM) && (cnt_q != 2'd0));
  assign last_beat = (sent_q == len_q - DEPTH_EXP'(1));
  assign m_last    = (state_q == STREAM) && (cnt_q != 2'd0) && last_beat;
  assign m_data    = m_first ? WORD_WIDTH'(len_q) :
                     (state_q == STREAM) ? buf0_q : '0;

  assign xfer     = m_valid && m_ready;
  assign pay_xfer = xfer && (state_q == STREAM);

  // Occupancy once this cycle's beat leaves and the in-flight word lands.
  assign occ = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pay_xfer};

  // Popping starts in HEADER so payload follows the header closely.
  assign fifo_rd_en = (state_q != IDLE) && fifo_valid &&
                      (popped_q < len_q) && (occ < 3'd2);

  assign busy        = (state_q != IDLE);
  assign burst_count = count_q;

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      len_q      <= '0;
      popped_q   <= '0;
      sent_q     <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      inflight_q <= fifo_rd_en;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            timer_q  <= '0;
            len_q    <= (fifo_rd_data_count >= BLEN) ? BLEN
                                                     : fifo_rd_data_count;
            popped_q <= '0;
            sent_q   <= '0;
            state_q  <= HEADER;
          end else if (fifo_rd_data_count == '0) begin
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        HEADER: begin
          if (fifo_rd_en) popped_q <= popped_q + DEPTH_EXP'(1);
          if (m_ready) state_q <= STREAM;
        end
        STREAM: begin
          if (fifo_rd_en) popped_q <= popped_q + DEPTH_EXP'(1);
          if (pay_xfer) sent_q <= sent_q + DEPTH_EXP'(1);
          if (pay_xfer && last_beat) begin
            count_q <= count_q + 16'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (inflight_q && pay_xfer) begin
        if (cnt_q == 2'd2) begin
          buf0_q <= buf1_q;
          buf1_q <= fifo_dout;
        end else begin
          buf0_q <= fifo_dout;
        end
      end else if (pay_xfer) begin
        buf0_q <= buf1_q;
        cnt_q  <= cnt_q - 2'd1;
      end else if (inflight_q) begin
        if (cnt_q == 2'd0) buf0_q <= fifo_dout;
        else               buf1_q <= fifo_dout;
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader.
// FIFO model feeds the DUT; a negedge monitor logs stream beats.
module tb_fifo_burst_reader;

  localparam int WW = 16;
  localparam int DE = 10;
  localparam int BL = 4;
  localparam int TO = 8;

  logic          rd_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [WW-1:0] fifo_dout = '0;
  logic          fifo_valid;
  logic [DE-1:0] fifo_rd_data_count;
  logic          fifo_rd_en;
  logic [WW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_first;
  logic          m_last;
  logic          busy;
  logic [15:0]   burst_count;

  always #5 rd_clk = ~rd_clk;

  fifo_burst_reader #(
    .WORD_WIDTH(WW),
    .DEPTH_EXP (DE),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .rd_clk            (rd_clk),
    .reset_n           (reset_n),
    .fifo_dout         (fifo_dout),
    .fifo_valid        (fifo_valid),
    .fifo_rd_data_count(fifo_rd_data_count),
    .fifo_rd_en        (fifo_rd_en),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_first           (m_first),
    .m_last            (m_last),
    .busy              (busy),
    .burst_count       (burst_count)
  );

  logic [WW-1:0] mem [0:255];
  int   head = 0;
  int   tail = 0;
  logic vlow = 1'b0;
  logic flush = 1'b0;

  assign fifo_valid         = (tail > head) && !vlow;
  assign fifo_rd_data_count = DE'(tail - head);

  always @(posedge rd_clk) begin
    if (flush) begin
      head <= tail;
    end else if (fifo_rd_en && fifo_valid) begin
      fifo_dout <= mem[head];
      head      <= head + 1;
    end
  end

  int            ncyc = 0;
  int            nbeat = 0;
  int            rd_cnt = 0;
  int            rdv_err = 0;
  int            stab_err = 0;
  int            stall_cnt = 0;
  int            gap_cnt = 0;
  logic          in_pay = 1'b0;
  logic          ps = 1'b0;
  logic [WW+1:0] pv = '0;
  logic [WW-1:0] lg_d [0:127];
  logic          lg_f [0:127];
  logic          lg_l [0:127];
  int            lg_c [0:127];

  always @(negedge rd_clk) begin
    ncyc++;
    if (reset_n) begin
      if (fifo_rd_en) rd_cnt++;
      if (fifo_rd_en && !fifo_valid) rdv_err++;
      if (ps && (!m_valid || {m_first, m_last, m_data} !== pv)) stab_err++;
      if (m_valid && !m_ready) stall_cnt++;
      if (busy && !m_valid && in_pay) gap_cnt++;
      if (m_valid && m_ready && nbeat < 128) begin
        lg_d[nbeat] = m_data;
        lg_f[nbeat] = m_first;
        lg_l[nbeat] = m_last;
        lg_c[nbeat] = ncyc;
        nbeat++;
        if (!m_first) in_pay = !m_last;
      end
      ps = m_valid && !m_ready;
      pv = {m_first, m_last, m_data};
    end else begin
      ps     = 1'b0;
      in_pay = 1'b0;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [WW-1:0] w);
    mem[tail] = w;
    tail++;
  endtask

  task automatic wait_bc(input int n, input int lim, input string tag);
    int k = 0;
    while (32'(burst_count) != n && k < lim) begin
      @(negedge rd_clk);
      k++;
    end
    chk(tag, 32'(burst_count), n);
  endtask

  task automatic chk_burst(input int b0, input int hdr,
                           input logic [WW-1:0] w0, input string tag);
    chk($sformatf("%s_hdr", tag),
        {14'b0, lg_f[b0], lg_l[b0], lg_d[b0]},
        {14'b0, 1'b1, 1'b0, WW'(hdr)});
    for (int i = 1; i <= hdr; i++) begin
      chk($sformatf("%s_pay%0d", tag, i),
          {14'b0, lg_f[b0+i], lg_l[b0+i], lg_d[b0+i]},
          {14'b0, 1'b0, (i == hdr), w0 + WW'(i - 1)});
    end
  endtask

  int pat [6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    int b, r, s, g, rv, idle, k;

    reset_n = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;
    chk("rst_ctl", {27'b0, m_valid, m_first, m_last, fifo_rd_en, busy}, 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_bc", 32'(burst_count), 0);
    @(posedge rd_clk); #1 reset_n = 1'b1;
    @(posedge rd_clk); #1;

    // full burst
    b = nbeat; r = rd_cnt;
    for (int i = 0; i < 4; i++) push(WW'(16'h11 + i));
    wait_bc(1, 60, "t1_done");
    chk("t1_beats", nbeat - b, 5);
    chk_burst(b, 4, 16'h0011, "t1");
    chk("t1_pops", rd_cnt - r, 4);
    chk("t1_lat", 32'(lg_c[b+1] - lg_c[b] <= 2), 1);
    chk("t1_consec", lg_c[b+4] - lg_c[b+1], 3);

    // partial burst flushed by timeout
    @(posedge rd_clk); #1;
    b = nbeat; idle = 0;
    push(16'h0021); push(16'h0022);
    repeat (TO) begin
      @(negedge rd_clk);
      idle += int'(busy);
    end
    chk("t2_quiet", idle, 0);
    @(negedge rd_clk);
    chk("t2_start", {14'b0, busy, m_first, m_data}, {14'b0, 1'b1, 1'b1, 16'h0002});
    wait_bc(2, 60, "t2_done");
    chk("t2_beats", nbeat - b, 3);
    chk_burst(b, 2, 16'h0021, "t2");

    // 10 words -> 4, 4, 2
    @(posedge rd_clk); #1;
    b = nbeat;
    for (int i = 0; i < 10; i++) push(WW'(16'h31 + i));
    wait_bc(5, 300, "t3_done");
    chk("t3_beats", nbeat - b, 13);
    chk_burst(b, 4, 16'h0031, "t3a");
    chk_burst(b + 5, 4, 16'h0035, "t3b");
    chk_burst(b + 10, 2, 16'h0039, "t3c");

    // backpressure during payload
    @(posedge rd_clk); #1;
    b = nbeat; r = rd_cnt; s = stab_err; g = stall_cnt;
    for (int i = 0; i < 4; i++) push(WW'(16'h41 + i));
    k = 0;
    do begin
      @(negedge rd_clk);
      k++;
    end while (!(m_valid && m_first) && k < 50);
    for (int i = 0; i < 6; i++) begin
      @(posedge rd_clk); #1;
      m_ready = pat[i][0];
    end
    m_ready = 1'b1;
    wait_bc(6, 80, "t4_done");
    chk("t4_beats", nbeat - b, 5);
    chk_burst(b, 4, 16'h0041, "t4");
    chk("t4_pops", rd_cnt - r, 4);
    chk("t4_stable", stab_err - s, 0);
    chk("t4_stalled", 32'(stall_cnt - g > 0), 1);

    // FIFO runs dry mid-burst
    @(posedge rd_clk); #1;
    b = nbeat; r = rd_cnt; rv = rdv_err; g = gap_cnt;
    for (int i = 0; i < 4; i++) push(WW'(16'h51 + i));
    k = 0;
    while (rd_cnt - r < 2 && k < 50) begin
      @(negedge rd_clk);
      k++;
    end
    @(posedge rd_clk); #1 vlow = 1'b1;
    repeat (5) @(posedge rd_clk);
    #1 vlow = 1'b0;
    wait_bc(7, 80, "t5_done");
    chk("t5_beats", nbeat - b, 5);
    chk_burst(b, 4, 16'h0051, "t5");
    chk("t5_pops", rd_cnt - r, 4);
    chk("t5_rd_dry", rdv_err - rv, 0);
    chk("t5_gap", 32'(gap_cnt - g >= 3), 1);

    // reset mid-burst
    @(posedge rd_clk); #1;
    b = nbeat;
    for (int i = 0; i < 4; i++) push(WW'(16'h61 + i));
    k = 0;
    while (nbeat - b < 3 && k < 50) begin
      @(negedge rd_clk);
      k++;
    end
    @(posedge rd_clk); #1;
    reset_n = 1'b0;
    flush   = 1'b1;
    #2;
    chk("t6_rst_ctl", {27'b0, m_valid, m_first, m_last, fifo_rd_en, busy}, 0);
    chk("t6_rst_data", 32'(m_data), 0);
    chk("t6_rst_bc", 32'(burst_count), 0);
    @(posedge rd_clk); #1;
    flush   = 1'b0;
    reset_n = 1'b1;
    @(negedge rd_clk);
    chk("t6_idle", 32'(busy), 0);
    @(posedge rd_clk); #1;
    b = nbeat;
    for (int i = 0; i < 4; i++) push(WW'(16'h71 + i));
    wait_bc(1, 60, "t6_done");
    chk("t6_beats", nbeat - b, 5);
    chk_burst(b, 4, 16'h0071, "t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
